// File: rtl/xor_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : xor_parity_rx
// Brief    : Serial start/data/parity/stop deframer with valid/ready output.
// Revision : 1.0
// ============================================================================
module xor_parity_rx #(
    parameter int DATA_W  = 8,
    parameter int ODD_PAR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              par_err,
    output logic              frm_err,
    output logic              overrun,
    output logic              busy
);

    localparam int              CNT_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);
    localparam logic            C_ODD  = (ODD_PAR != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                rpar_q, rpar_d;
    logic                perr_q, perr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                par_err_q, par_err_d;
    logic                frm_err_q, frm_err_d;
    logic                overrun_q, overrun_d;
    logic                busy_q;
    logic                done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        rpar_d    = rpar_q;
        perr_d    = perr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        overrun_d = overrun_q;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bit_en && !ser_in) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    shift_d = '0;
                    rpar_d  = 1'b0;
                end
            end
            S_DATA: begin
                if (bit_en) begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (cnt_q == CNT_W'(i)) shift_d[i] = ser_in;
                    end
                    rpar_d = rpar_q ^ ser_in;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == C_LAST) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (bit_en) begin
                    perr_d  = rpar_q ^ ser_in ^ C_ODD;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_en) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A completing frame may replace a word accepted on the same cycle.
        if (done) begin
            if (!valid_q || out_ready) begin
                data_d    = shift_q;
                par_err_d = perr_q;
                frm_err_d = ~ser_in;
                valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            rpar_q    <= 1'b0;
            perr_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            rpar_q    <= rpar_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            overrun_q <= overrun_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign par_err   = par_err_q;
    assign frm_err   = frm_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_parity_rx
// Brief    : Directed bench for xor_parity_rx (even-parity and odd-parity instances).
// Revision : 1.0
// ============================================================================
module tb_xor_parity_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ser_in = 1'b1;
    logic       bit_en = 1'b0;
    logic       out_ready = 1'b0;
    logic       sel = 1'b0;

    logic       bit_en_a, bit_en_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
    logic       ovr_a, ovr_b, busy_a, busy_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign bit_en_a = bit_en & ~sel;
    assign bit_en_b = bit_en & sel;

    xor_parity_rx #(.DATA_W(8), .ODD_PAR(0)) u_even (
        .clk(clk), .rst(rst), .ser_in(ser_in), .bit_en(bit_en_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready),
        .par_err(perr_a), .frm_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
    );

    xor_parity_rx #(.DATA_W(8), .ODD_PAR(1)) u_odd (
        .clk(clk), .rst(rst), .ser_in(ser_in), .bit_en(bit_en_b),
        .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready),
        .par_err(perr_b), .frm_err(ferr_b), .overrun(ovr_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Idle (no strobe) for gap cycles, then present one strobed bit.
    task automatic send_bit(input logic b, input int gap);
        bit_en = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        ser_in = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        ser_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int gap, input logic rdy_at_stop);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(par, gap);
        if (rdy_at_stop) out_ready = 1'b1;
        send_bit(stp, gap);
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_outs", {24'd0, data_a} | {28'd0, perr_a, ferr_a, ovr_a, busy_a}, 32'd0);
        tick(); tick();
        #2 rst = 1'b0;
        tick();

        // Idle line with strobe every cycle
        ser_in = 1'b1;
        bit_en = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        bit_en = 1'b0;
        chk("idle_busy", {31'd0, busy_a}, 32'd0);
        chk("idle_valid", {31'd0, valid_a}, 32'd0);

        // 0xA5 even parity -> parity bit 0
        out_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
        chk("a5_valid", {31'd0, valid_a}, 32'd1);
        chk("a5_data", {24'd0, data_a}, 32'hA5);
        chk("a5_flags", {30'd0, perr_a, ferr_a}, 32'd0);
        tick();
        chk("a5_accept", {31'd0, valid_a}, 32'd0);

        // 0x01 needs parity 1; sending 0 is a parity error
        send_frame(8'h01, 1'b0, 1'b1, 0, 1'b0);
        chk("01_perr", {31'd0, perr_a}, 32'd1);
        chk("01_data", {24'd0, data_a}, 32'h01);

        // Framing error then back-to-back good frame
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
        chk("3c_data", {24'd0, data_a}, 32'h3C);
        chk("3c_flags", {29'd0, valid_a, perr_a, ferr_a}, 32'b101);
        send_frame(8'h55, 1'b0, 1'b1, 0, 1'b0);
        chk("55_data", {24'd0, data_a}, 32'h55);
        chk("55_flags", {29'd0, valid_a, perr_a, ferr_a}, 32'b100);
        tick();

        // Backpressure and overrun
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
        chk("11_valid", {31'd0, valid_a}, 32'd1);
        chk("11_ovr0", {31'd0, ovr_a}, 32'd0);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0);
        chk("ovr_data", {24'd0, data_a}, 32'h11);
        chk("ovr_set", {31'd0, ovr_a}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("ovr_accept", {31'd0, valid_a}, 32'd0);
        chk("ovr_sticky", {31'd0, ovr_a}, 32'd1);
        tick();

        // Asynchronous reset mid-cycle clears overrun before the next edge
        #2 rst = 1'b1;
        #1;
        chk("arst_ovr", {31'd0, ovr_a}, 32'd0);
        chk("arst_data", {24'd0, data_a}, 32'd0);
        #4 rst = 1'b0;
        tick();

        // Accept and complete on the same cycle
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
        chk("hold_11", {24'd0, data_a}, 32'h11);
        send_frame(8'h99, 1'b0, 1'b1, 0, 1'b1);
        chk("swap_data", {24'd0, data_a}, 32'h99);
        chk("swap_valid", {31'd0, valid_a}, 32'd1);
        chk("swap_ovr", {31'd0, ovr_a}, 32'd0);
        tick();

        // Odd parity instance with a strobe every 4th cycle
        sel = 1'b1;
        out_ready = 1'b1;
        send_frame(8'hFF, 1'b1, 1'b1, 3, 1'b0);
        chk("ff_data", {24'd0, data_b}, 32'hFF);
        chk("ff_flags", {29'd0, valid_b, perr_b, ferr_b}, 32'b100);
        tick();
        chk("ff_accept", {31'd0, valid_b}, 32'd0);

        // Reset during data bit 3 discards the partial frame
        send_bit(1'b0, 3);
        send_bit(1'b1, 3);
        send_bit(1'b1, 3);
        send_bit(1'b1, 3);
        tick();
        chk("mid_busy", {31'd0, busy_b}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy_b}, 32'd0);
        #4 rst = 1'b0;
        tick();
        send_frame(8'h0F, 1'b1, 1'b1, 3, 1'b0);
        chk("0f_data", {24'd0, data_b}, 32'h0F);
        chk("0f_flags", {29'd0, valid_b, perr_b, ferr_b}, 32'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
